// File: rtl/pulse_mem_loader.sv
// Write-side loader for the pulse memory: stages pulse fields from the
// config bus and commits the packed word to one slot or a wrapping burst.
module pulse_mem_loader #(
    parameter int DEPTH   = 32,
    parameter int FREQ_W  = 32,
    parameter int PHASE_W = 16,
    parameter int AMP_W   = 16,
    parameter int TLEN_W  = 16,
    parameter int ENV_W   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int WORD_W  = FREQ_W + PHASE_W + AMP_W + TLEN_W + ENV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              mem_we,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [15:0]       commit_count
);

    localparam logic [2:0] A_FREQ   = 3'd0;
    localparam logic [2:0] A_PHASE  = 3'd1;
    localparam logic [2:0] A_AMP    = 3'd2;
    localparam logic [2:0] A_TLEN   = 3'd3;
    localparam logic [2:0] A_ENV    = 3'd4;
    localparam logic [2:0] A_COMMIT = 3'd5;
    localparam logic [2:0] A_CLEAR  = 3'd6;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t             state;
    logic [FREQ_W-1:0]  freq_q;
    logic [PHASE_W-1:0] phase_q;
    logic [AMP_W-1:0]   amp_q;
    logic [TLEN_W-1:0]  tlen_q;
    logic [ENV_W-1:0]   env_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    rem_q;
    logic               done_q;
    logic               err_q;
    logic [15:0]        cnt_q;

    assign cfg_ready    = (state == IDLE);
    assign busy         = (state == WRITE);
    assign mem_we       = (state == WRITE);
    assign mem_waddr    = addr_q;
    assign mem_wdata    = {env_q, tlen_q, amp_q, phase_q, freq_q};
    assign done         = done_q;
    assign err          = err_q;
    assign commit_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            freq_q  <= '0;
            phase_q <= '0;
            amp_q   <= '0;
            tlen_q  <= '0;
            env_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        unique case (1'b1)
                            (cfg_addr == A_FREQ):  freq_q  <= cfg_wdata[FREQ_W-1:0];
                            (cfg_addr == A_PHASE): phase_q <= cfg_wdata[PHASE_W-1:0];
                            (cfg_addr == A_AMP):   amp_q   <= cfg_wdata[AMP_W-1:0];
                            (cfg_addr == A_TLEN):  tlen_q  <= cfg_wdata[TLEN_W-1:0];
                            (cfg_addr == A_ENV):   env_q   <= cfg_wdata[ENV_W-1:0];
                            (cfg_addr == A_COMMIT): begin
                                addr_q <= cfg_wdata[ADDR_W-1:0];
                                rem_q  <= {1'b0, cfg_wdata[ADDR_W+7:8]}
                                          + (ADDR_W+1)'(1);
                                state  <= WRITE;
                            end
                            (cfg_addr == A_CLEAR): begin
                                freq_q  <= '0;
                                phase_q <= '0;
                                amp_q   <= '0;
                                tlen_q  <= '0;
                                env_q   <= '0;
                                err_q   <= 1'b0;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                WRITE: begin
                    // Beat accepted: address wraps naturally at DEPTH
                    if (mem_wready) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - (ADDR_W+1)'(1);
                        cnt_q  <= cnt_q + 16'd1;
                        if (rem_q == (ADDR_W+1)'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pulse_mem_loader.md
# pulse_mem_loader

Write-side agent for the 32-entry pulse memory that the pulse fetch path reads. The RISC-V core stages pulse parameters field by field over a simple valid/ready config bus. A COMMIT command then packs the staged fields into one pulse-register word. The word is written into one slot, or a wrapping burst of slots, through a back-pressured memory write port.

## Interface
- DEPTH, 32, pulse memory entries; power of two; ADDR_W = $clog2(DEPTH)
- FREQ_W, 32, frequency field width (≤32)
- PHASE_W, 16, phase field width (≤32)
- AMP_W, 16, amplitude field width (≤32)
- TLEN_W, 16, pulse length field width (≤32)
- ENV_W, 8, envelope address width (≤32)
- WORD_W = FREQ_W+PHASE_W+AMP_W+TLEN_W+ENV_W (derived, 88 at defaults)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  loader can accept a config write
- cfg_addr  in  3  register select
- cfg_wdata  in  32  write data
- mem_we  out  1  memory write request
- mem_wready  in  1  memory accepts current write
- mem_waddr  out  ADDR_W  target slot
- mem_wdata  out  WORD_W  packed word {env, tlen, amp, phase, freq}, with freq in the LSBs
- done  out  1  one-cycle pulse when a commit completes
- busy  out  1  burst in progress
- err  out  1  sticky: access to a reserved address
- commit_count  out  16  total words written, wraps at 2^16

## Operation
- Config transfer occurs on a rising edge when cfg_valid && cfg_ready.
- cfg_ready = (state == IDLE).
- Register map, by cfg_addr:
  - 0 FREQ, 1 PHASE, 2 AMP, 3 TLEN, 4 ENV: load the staging register from cfg_wdata low bits. Upper bits are ignored.
  - 5 COMMIT:
    - start slot = cfg_wdata[ADDR_W-1:0]
    - burst length = cfg_wdata[ADDR_W+7:8] + 1, range 1..DEPTH
    - Other bits are ignored. Enter WRITE.
  - 6 CLEAR: zero all staging registers and clear err.
  - 7 reserved: set err. No other effect.
- The staging registers hold their values across commits. Only CLEAR or reset changes them. They cannot change during a burst because cfg_ready = 0.
- FSM:
  - IDLE → WRITE on COMMIT transfer. Load the address counter with the start slot and the remaining counter with the length.
  - WRITE: mem_we = 1, mem_waddr = address counter, mem_wdata = packed staging.
    - On each edge with mem_wready = 1: the address counter increments modulo DEPTH, the remaining counter decrements, and commit_count increments.
    - When the last beat is accepted → IDLE. done is registered high for the following single cycle.
- busy = (state == WRITE).
- Address wrap: a burst starting at DEPTH-1 continues at slot 0.
- A burst of length DEPTH writes every slot exactly once.
- The loader never issues a read. The fetch side owns reads. Arbitration is external, via mem_wready.

## Timing
- Reset values:
  - cfg_ready = 1
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0
  - done = 0, busy = 0, err = 0, commit_count = 0
  - staging registers = 0, state IDLE
- Asynchronous reset mid-burst: mem_we drops immediately and the burst is abandoned. Slots already written keep their data.
- COMMIT accepted at edge N:
  - mem_we is high from cycle N+1.
  - With mem_wready held at 1, a length-k burst occupies cycles N+1..N+k.
  - In cycle N+k+1: done = 1 and cfg_ready = 1.
  - A new COMMIT can be accepted at the end of cycle N+k+1.
- mem_wready = 0: mem_we, mem_waddr and mem_wdata hold stable until the beat is accepted. There is no timeout.
- Field-to-commit latency: a field written at edge N is visible in mem_wdata for a COMMIT accepted at edge N+1.
- cfg_valid asserted while busy: no transfer. The request must be held by the core.
- commit_count wraps from 0xFFFF to 0x0000.

## Test plan
- **Reset.** Pulse rst_n low, then release. Require cfg_ready = 1, mem_we = 0, and done, busy, err and commit_count all 0.
- **Single write.** Stage freq = 0x12345678, phase = 0x0400, amp = 0x7FFF, tlen = 0x0100, env = 0x05. COMMIT with wdata = 0x00000003. Hold mem_wready = 1.
  - Require exactly one beat: mem_waddr = 3, mem_wdata = 0x05_0100_7FFF_0400_12345678.
  - Then done for one cycle, commit_count = 1.
- **Wrap burst.** COMMIT with wdata = 0x0000031E (slot 30, length 4). Require beats to slots 30, 31, 0, 1 with identical data, and commit_count incremented by 4.
- **Backpressure.** Hold mem_wready = 0 for 3 cycles during beat 2 of a 3-beat burst.
  - Require mem_waddr and mem_wdata stable throughout. A cfg_valid FREQ write during the stall is not accepted.
  - The burst completes with the original data, and the pending FREQ write transfers after done.
- **Error and clear.** Write cfg_addr 7 → err = 1 and no mem_we. Then CLEAR → err = 0. Then COMMIT slot 5 → mem_wdata = 0 at slot 5.
- **Reset mid-burst.** Assert rst_n low during beat 2 of a length-4 burst. Require mem_we = 0 in the same cycle and all outputs at their reset values. After release, a new COMMIT to slot 9 writes the zeroed staging word.
